gpio_pad_arbiter: RTL and testbench

- Round-robin arbiter that shares one bank of user-project GPIO pads (mprj_io outputs and active-low output enables) among NUM_REQ on-chip requesters. Example requesters: the team core, a debug/LA path and a test-pattern generator.
- Sits between the team's Wishbone-wrapped design and the Caravel mprj_io pads.
- Guarantees exclusive pad ownership. Inserts a released-bus turnaround between owners so no two drivers ever contend.

---
 rtl/gpio_pad_arbiter_if.sv | 29 ++
 rtl/gpio_pad_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_gpio_pad_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pad_arbiter_if.sv
// Requester-side bundle for the GPIO pad arbiter: enable, per-requester
// requests and pad slices, plus the shared pad drive and grant status.
interface gpio_pad_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                     en;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_out;
   logic [NUM_REQ*WIDTH-1:0] req_oeb;
   logic [WIDTH-1:0]         gpio_out;
   logic [WIDTH-1:0]         gpio_oeb;
   logic [NUM_REQ-1:0]       grant;
   logic [IDX_W-1:0]         grant_idx;
   logic                     busy;
   logic                     timeout;

   modport master (
      output en, req, req_out, req_oeb,
      input  gpio_out, gpio_oeb, grant, grant_idx, busy, timeout
   );

   modport slave (
      input  en, req, req_out, req_oeb,
      output gpio_out, gpio_oeb, grant, grant_idx, busy, timeout
   );
endinterface

// File: rtl/gpio_pad_arbiter.sv
// Round-robin owner arbiter for a shared bank of mprj_io pads.
// One requester owns the pads at a time; ownership changes always pass
// through a released-bus turnaround (pads high-Z, grant zero).
// Optional hold-time preemption: define GPIO_PAD_ARBITER_TIMEOUT_EN.
module gpio_pad_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 1,
   parameter int HOLD_MAX    = 255,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              nrst,
   gpio_pad_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t             state_r;
   logic [NUM_REQ-1:0] grant_r;
   logic [IDX_W-1:0]   last_idx_r;
   logic [WIDTH-1:0]   gpio_out_r;
   logic [WIDTH-1:0]   gpio_oeb_r;
   logic               busy_r;
   logic               timeout_r;
   logic [CNT_W-1:0]   turn_cnt_r;

   logic [IDX_W-1:0]   sel_s;
   logic               any_req_s;
   logic               owner_req_s;
   logic               start_s;
   logic               release_s;
   logic               preempt_s;
   logic               turn_done_s;

`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
   logic [CNT_W-1:0]   hold_cnt_r;
   logic [CNT_W-1:0]   hold_nxt_s;
   logic               others_req_s;
`endif

   // Extract one requester's WIDTH-bit slice from a packed per-requester bus.
   function automatic logic [WIDTH-1:0] pick_slice(
      input logic [NUM_REQ*WIDTH-1:0] vec,
      input logic [IDX_W-1:0]         idx
   );
      pick_slice = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pick_slice = pick_slice | ((idx == IDX_W'(i)) ? vec[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
      end
   endfunction

   // One-hot encode a requester index.
   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
      to_onehot = '0;
      to_onehot[idx] = 1'b1;
   endfunction

   // Round-robin pick: first requester after last_idx, wrapping around.
   always_comb begin
      logic found;
      found = 1'b0;
      sel_s = last_idx_r;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && bus.req[(int'(last_idx_r) + k) % NUM_REQ]) begin
            found = 1'b1;
            sel_s = IDX_W'((int'(last_idx_r) + k) % NUM_REQ);
         end else begin
            found = found;
         end
      end
   end

   // Request summary and transition conditions shared by the FSM.
   always_comb begin
      any_req_s   = |bus.req;
      owner_req_s = |(bus.req & grant_r);
      start_s     = bus.en && any_req_s;
      turn_done_s = (turn_cnt_r == CNT_W'(TURN_CYCLES - 1));
      release_s   = !bus.en || !owner_req_s || preempt_s;
   end

`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
   // Saturating hold count and preemption once the owner reaches HOLD_MAX cycles with a competitor waiting.
   always_comb begin
      others_req_s = |(bus.req & ~grant_r);
      if (hold_cnt_r == CNT_W'(HOLD_MAX)) begin
         hold_nxt_s = hold_cnt_r;
      end else begin
         hold_nxt_s = hold_cnt_r + CNT_W'(1);
      end
      preempt_s = (hold_nxt_s == CNT_W'(HOLD_MAX)) && others_req_s;
   end
`else
   assign preempt_s = 1'b0;
`endif

   // Arbiter FSM with registered grant, pad drive and status outputs.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_r    <= ST_IDLE;
         grant_r    <= '0;
         last_idx_r <= IDX_W'(NUM_REQ - 1);
         gpio_out_r <= '0;
         gpio_oeb_r <= {WIDTH{1'b1}};
         busy_r     <= 1'b0;
         timeout_r  <= 1'b0;
         turn_cnt_r <= '0;
`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
         hold_cnt_r <= '0;
`endif
      end else begin
         timeout_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r    <= ST_GRANT;
                  busy_r     <= 1'b1;
                  grant_r    <= to_onehot(sel_s);
                  last_idx_r <= sel_s;
                  gpio_out_r <= pick_slice(bus.req_out, sel_s);
                  gpio_oeb_r <= pick_slice(bus.req_oeb, sel_s);
`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
                  hold_cnt_r <= '0;
`endif
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (release_s) begin
                  // Owner let go (or was preempted): release the pads first.
                  state_r    <= ST_TURN;
                  busy_r     <= 1'b1;
                  grant_r    <= '0;
                  gpio_out_r <= '0;
                  gpio_oeb_r <= {WIDTH{1'b1}};
                  turn_cnt_r <= '0;
                  timeout_r  <= preempt_s;
               end else begin
                  state_r    <= ST_GRANT;
                  gpio_out_r <= pick_slice(bus.req_out, last_idx_r);
                  gpio_oeb_r <= pick_slice(bus.req_oeb, last_idx_r);
`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
                  hold_cnt_r <= hold_nxt_s;
`endif
               end
            end
            ST_TURN: begin
               if (turn_done_s) begin
                  if (start_s) begin
                     state_r    <= ST_GRANT;
                     busy_r     <= 1'b1;
                     grant_r    <= to_onehot(sel_s);
                     last_idx_r <= sel_s;
                     gpio_out_r <= pick_slice(bus.req_out, sel_s);
                     gpio_oeb_r <= pick_slice(bus.req_oeb, sel_s);
`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
                     hold_cnt_r <= '0;
`endif
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  state_r    <= ST_TURN;
                  turn_cnt_r <= turn_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               grant_r    <= '0;
               gpio_out_r <= '0;
               gpio_oeb_r <= {WIDTH{1'b1}};
            end
         endcase
      end
   end

   assign bus.grant     = grant_r;
   assign bus.grant_idx = last_idx_r;
   assign bus.gpio_out  = gpio_out_r;
   assign bus.gpio_oeb  = gpio_oeb_r;
   assign bus.busy      = busy_r;
   assign bus.timeout   = timeout_r;

`ifndef SYNTHESIS
   gpio_pad_arbiter_chk #(
      .NUM_REQ     (NUM_REQ),
      .WIDTH       (WIDTH),
      .TURN_CYCLES (TURN_CYCLES),
      .HOLD_MAX    (HOLD_MAX),
      .CNT_W       (CNT_W)
   ) u_chk (
      .clk      (clk),
      .nrst     (nrst),
      .grant    (grant_r),
      .gpio_oeb (gpio_oeb_r),
      .busy     (busy_r)
   );
`endif
endmodule

// Simulation-only property checker for the pad arbiter.
module gpio_pad_arbiter_chk #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 1,
   parameter int HOLD_MAX    = 255,
   parameter int CNT_W       = 8
) (
   input logic               clk,
   input logic               nrst,
   input logic [NUM_REQ-1:0] grant,
   input logic [WIDTH-1:0]   gpio_oeb,
   input logic               busy
);
   // Never more than one owner.
   a_grant_onehot0: assert property (@(posedge clk) disable iff (!nrst) $onehot0(grant));

   // Pads are released whenever nobody owns them.
   a_released_no_owner: assert property (@(posedge clk) disable iff (!nrst)
      (grant == '0) |-> (gpio_oeb == {WIDTH{1'b1}}));

   // An owner implies the arbiter reports busy.
   a_grant_busy: assert property (@(posedge clk) disable iff (!nrst) (grant != '0) |-> busy);

   // Configuration sanity: counters must hold the programmed limits.
   a_cfg: assert property (@(posedge clk)
      (TURN_CYCLES >= 1) && (TURN_CYCLES <= (1 << CNT_W)) &&
      (HOLD_MAX >= 1) && (HOLD_MAX < (1 << CNT_W)));
endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Randomized bench for gpio_pad_arbiter: two instances (turnaround 1 and 3)
// share one stimulus stream and are compared every cycle against a
// cycle-level ownership model kept in the bench.
module tb_gpio_pad_arbiter;
   localparam int NR   = 4;
   localparam int W    = 8;
   localparam int HOLD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              nrst_s;
   logic              en_s;
   logic [NR-1:0]     req_s;
   logic [NR*W-1:0]   out_s;
   logic [NR*W-1:0]   oeb_s;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // model state, index 0 = dut_a, 1 = dut_b
   int         m_owner [2];
   int         m_turn  [2];
   int         m_last  [2];
   int         m_held  [2];
   logic       m_to    [2];
   logic [W-1:0] m_out [2];
   logic [W-1:0] m_oeb [2];
   int         turn_cfg [2] = '{1, 3};

   gpio_pad_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) if_a ();
   gpio_pad_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) if_b ();

   assign if_a.en      = en_s;
   assign if_a.req     = req_s;
   assign if_a.req_out = out_s;
   assign if_a.req_oeb = oeb_s;
   assign if_b.en      = en_s;
   assign if_b.req     = req_s;
   assign if_b.req_out = out_s;
   assign if_b.req_oeb = oeb_s;

   gpio_pad_arbiter #(
      .NUM_REQ(NR), .WIDTH(W), .TURN_CYCLES(1), .HOLD_MAX(HOLD), .CNT_W(8)
   ) dut_a (
      .clk  (clk),
      .nrst (nrst_s),
      .bus  (if_a)
   );

   gpio_pad_arbiter #(
      .NUM_REQ(NR), .WIDTH(W), .TURN_CYCLES(3), .HOLD_MAX(HOLD), .CNT_W(8)
   ) dut_b (
      .clk  (clk),
      .nrst (nrst_s),
      .bus  (if_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic try_pick(input int d);
      bit found;
      int c;
      found = 1'b0;
      if (en_s && (req_s != '0)) begin
         for (int k = 1; k <= NR; k++) begin
            c = (m_last[d] + k) % NR;
            if (!found && req_s[c]) begin
               found      = 1'b1;
               m_owner[d] = c;
               m_last[d]  = c;
               m_held[d]  = 0;
            end
         end
      end
   endtask

   task automatic model_edge();
      bit pre;
      logic [NR-1:0] mask;
      for (int d = 0; d < 2; d++) begin
         m_to[d] = 1'b0;
         if (!nrst_s) begin
            m_owner[d] = -1;
            m_turn[d]  = 0;
            m_last[d]  = NR - 1;
            m_held[d]  = 0;
         end else if (m_owner[d] >= 0) begin
            m_held[d]++;
            mask = 4'b0001 << m_owner[d];
            pre  = 1'b0;
`ifdef GPIO_PAD_ARBITER_TIMEOUT_EN
            pre = (m_held[d] >= HOLD) && ((req_s & ~mask) != '0);
`endif
            if (!en_s || ((req_s & mask) == '0) || pre) begin
               m_owner[d] = -1;
               m_turn[d]  = turn_cfg[d];
               m_to[d]    = pre;
            end
         end else if (m_turn[d] > 0) begin
            m_turn[d]--;
            if (m_turn[d] == 0) try_pick(d);
         end else begin
            try_pick(d);
         end
         if (m_owner[d] >= 0) begin
            m_out[d] = out_s[m_owner[d]*W +: W];
            m_oeb[d] = oeb_s[m_owner[d]*W +: W];
         end else begin
            m_out[d] = 8'h00;
            m_oeb[d] = 8'hFF;
         end
      end
   endtask

   task automatic check_dut(input int d, input string nm,
                            input logic [NR-1:0] g, input logic [1:0] gi,
                            input logic [W-1:0] go, input logic [W-1:0] goe,
                            input logic b, input logic t);
      logic [NR-1:0] eg;
      eg = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
      chk({nm, ".grant"},     32'(g),   32'(eg));
      chk({nm, ".grant_idx"}, 32'(gi),  32'(m_last[d]));
      chk({nm, ".gpio_out"},  32'(go),  32'(m_out[d]));
      chk({nm, ".gpio_oeb"},  32'(goe), 32'(m_oeb[d]));
      chk({nm, ".busy"},      32'(b),   32'((m_owner[d] >= 0) || (m_turn[d] > 0)));
      chk({nm, ".timeout"},   32'(t),   32'(m_to[d]));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_dut(0, "a", if_a.grant, if_a.grant_idx, if_a.gpio_out, if_a.gpio_oeb, if_a.busy, if_a.timeout);
      check_dut(1, "b", if_b.grant, if_b.grant_idx, if_b.gpio_out, if_b.gpio_oeb, if_b.busy, if_b.timeout);
      @(negedge clk);
   endtask

   initial begin
      // reset with everyone requesting
      nrst_s = 1'b0;
      en_s   = 1'b1;
      req_s  = 4'b1111;
      out_s  = $urandom;
      oeb_s  = $urandom;
      step();
      step();
      nrst_s = 1'b1;
      repeat (3) step();

      // round robin: owner drops for one cycle after three grant cycles
      for (int g = 0; g < 6; g++) begin
         repeat (3) step();
         if (m_owner[0] >= 0) req_s[m_owner[0]] = 1'b0;
         step();
         req_s = 4'b1111;
      end

      // single owner with slice data changes
      req_s = 4'b0000;
      repeat (5) step();
      req_s           = 4'b0100;
      out_s[23:16]    = 8'hA5;
      oeb_s[23:16]    = 8'h00;
      repeat (3) step();
      out_s[23:16]    = 8'h3C;
      repeat (3) step();

      // owner hand-over through the turnaround
      req_s = 4'b0001;
      repeat (6) step();
      req_s = 4'b0011;
      repeat (3) step();
      req_s = 4'b0010;
      repeat (8) step();

      // enable drop while someone owns the pads
      req_s = 4'b1111;
      repeat (4) step();
      en_s = 1'b0;
      repeat (8) step();
      en_s = 1'b1;
      repeat (4) step();

      // two contenders held high: preemption only with the hold feature
      req_s = 4'b0011;
      repeat (20) step();

      // reset in the middle of a grant
      nrst_s = 1'b0;
      step();
      nrst_s = 1'b1;
      repeat (4) step();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < NR; b++) begin
            if ($urandom_range(0, 7) == 0) req_s[b] = ~req_s[b];
         end
         if ($urandom_range(0, 31) == 0) en_s = ~en_s;
         nrst_s = ($urandom_range(0, 149) != 0);
         out_s  = $urandom;
         oeb_s  = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
